// File: rtl/si5340_i2c_arbiter.sv
// Round-robin arbiter that lets N_REQ clients share one Si5340 I2C register-access engine.
// Optional response watchdog is compiled in with `define ARB_TIMEOUT_EN.
module si5340_i2c_arbiter #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    output logic [N_REQ-1:0]   req_ready_o,
    input  logic [N_REQ-1:0]   req_rnw_i,
    input  logic [7*N_REQ-1:0] req_dev_i,
    input  logic [8*N_REQ-1:0] req_reg_i,
    input  logic [8*N_REQ-1:0] req_wdata_i,
    output logic [N_REQ-1:0]   rsp_valid_o,
    output logic [7:0]         rsp_rdata_o,
    output logic               rsp_err_o,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic               m_rnw_o,
    output logic [6:0]         m_dev_o,
    output logic [7:0]         m_reg_o,
    output logic [7:0]         m_wdata_o,
    input  logic               m_rsp_valid_i,
    input  logic [7:0]         m_rdata_i,
    input  logic               m_nack_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("si5340_i2c_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] pick;
    logic             pick_found;
    int               idx;

    logic             rnw_q;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q;
    logic [7:0]       wdata_q;
    logic [7:0]       rdata_q;
    logic             err_q;
    logic             wd_hit;

    logic accept;
    logic issue;
    logic resp;

    assign issue  = (state == S_ISSUE);
    assign resp   = (state == S_RESP);
    assign accept = (state == S_IDLE) && pick_found;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (!pick_found && req_valid_i[idx]) begin
                pick_found = 1'b1;
                pick       = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[pick] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_found) state_nxt = S_ISSUE;
            S_ISSUE: if (m_ready_i) state_nxt = S_WAIT;
            S_WAIT:  if (m_rsp_valid_i || wd_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            grant_o <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner   <= pick;
                grant_o <= N_REQ'(1) << pick;
            end
            if (resp) begin
                rr_ptr  <= (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
                grant_o <= '0;
            end
        end
    end

    // Command and response payload; outputs are gated by state so no reset is needed here.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rnw_q   <= req_rnw_i[pick];
            dev_q   <= req_dev_i[int'(pick)*7 +: 7];
            reg_q   <= req_reg_i[int'(pick)*8 +: 8];
            wdata_q <= req_wdata_i[int'(pick)*8 +: 8];
        end
        if (state == S_WAIT) begin
            if (m_rsp_valid_i) begin
                rdata_q <= rnw_q ? m_rdata_i : 8'h00;
                err_q   <= m_nack_i;
            end else if (wd_hit) begin
                rdata_q <= 8'h00;
                err_q   <= 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_q;

    // The response always wins over an expiry landing in the same cycle.
    assign wd_hit = (state == S_WAIT) && !m_rsp_valid_i &&
                    (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (state != S_WAIT) begin
            wd_cnt <= '0;
        end else if (wd_hit) begin
            timeout_q <= 1'b1;
        end else if (!m_rsp_valid_i) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign m_valid_o = issue;
    assign m_rnw_o   = issue & rnw_q;
    assign m_dev_o   = issue ? dev_q : 7'h00;
    assign m_reg_o   = issue ? reg_q : 8'h00;
    assign m_wdata_o = issue ? wdata_q : 8'h00;

    always_comb begin
        rsp_valid_o = '0;
        if (resp) begin
            rsp_valid_o[owner] = 1'b1;
        end
    end

    assign rsp_rdata_o = resp ? rdata_q : 8'h00;
    assign rsp_err_o   = resp & err_q;
    assign busy_o      = (state != S_IDLE);

endmodule

// File: tb/tb_si5340_i2c_arbiter.sv
// Scoreboard bench for si5340_i2c_arbiter: queued requesters, a scripted engine and
// negedge monitors that pop expected commands/responses as the DUT presents them.
module tb_si5340_i2c_arbiter;

    localparam int N   = 2;
    localparam int TOC = 16;

    typedef struct packed {
        logic       rnw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
    } cmd_t;

    typedef struct {
        int   k;
        cmd_t c;
    } xcmd_t;

    typedef struct {
        int         k;
        logic [7:0] rdata;
        logic       err;
        int         lat;
    } xrsp_t;

    typedef struct {
        int         delay;
        logic [7:0] rdata;
        logic       nack;
    } eng_t;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_ready_o;
    logic [N-1:0]   req_rnw_i;
    logic [7*N-1:0] req_dev_i;
    logic [8*N-1:0] req_reg_i;
    logic [8*N-1:0] req_wdata_i;
    logic [N-1:0]   rsp_valid_o;
    logic [7:0]     rsp_rdata_o;
    logic           rsp_err_o;
    logic           m_valid_o;
    logic           m_ready_i;
    logic           m_rnw_o;
    logic [6:0]     m_dev_o;
    logic [7:0]     m_reg_o;
    logic [7:0]     m_wdata_o;
    logic           m_rsp_valid_i;
    logic [7:0]     m_rdata_i;
    logic           m_nack_i;
    logic [N-1:0]   grant_o;
    logic           busy_o;
    logic           timeout_o;

    si5340_i2c_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TOC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_rnw_i(req_rnw_i), .req_dev_i(req_dev_i),
        .req_reg_i(req_reg_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_rnw_o(m_rnw_o),
        .m_dev_o(m_dev_o), .m_reg_o(m_reg_o), .m_wdata_o(m_wdata_o),
        .m_rsp_valid_i(m_rsp_valid_i), .m_rdata_i(m_rdata_i), .m_nack_i(m_nack_i),
        .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    int    mv_cycles = 0;
    int    hs_count = 0;
    int    hs_cyc = 0;
    int    rsp_cyc = 0;
    int    acc_cyc [N];
    logic  eng_busy = 1'b0;

    cmd_t  rq0 [$];
    cmd_t  rq1 [$];
    xcmd_t exp_cmd [$];
    xrsp_t exp_rsp [$];
    eng_t  eng_q [$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Requester driver: each slot presents the head of its queue until accepted.
    initial begin : requesters
        logic [N-1:0] rdy;
        logic         rst_s;
        req_valid_i = '0;
        req_rnw_i   = '0;
        req_dev_i   = '0;
        req_reg_i   = '0;
        req_wdata_i = '0;
        forever begin
            req_valid_i[0] = (rq0.size() > 0);
            req_valid_i[1] = (rq1.size() > 0);
            if (rq0.size() > 0) begin
                req_rnw_i[0]      = rq0[0].rnw;
                req_dev_i[6:0]    = rq0[0].dev;
                req_reg_i[7:0]    = rq0[0].rg;
                req_wdata_i[7:0]  = rq0[0].wd;
            end
            if (rq1.size() > 0) begin
                req_rnw_i[1]      = rq1[0].rnw;
                req_dev_i[13:7]   = rq1[0].dev;
                req_reg_i[15:8]   = rq1[0].rg;
                req_wdata_i[15:8] = rq1[0].wd;
            end
            @(negedge clk_i);
            rdy   = req_ready_o;
            rst_s = rst_i;
            if (rdy[0]) acc_cyc[0] = cyc;
            if (rdy[1]) acc_cyc[1] = cyc;
            if (rdy == 2'b11) chk("ready_onehot", 32'(rdy), 32'h1);
            @(posedge clk_i);
            #1;
            if (rdy[0] && !rst_s && rq0.size() > 0) void'(rq0.pop_front());
            if (rdy[1] && !rst_s && rq1.size() > 0) void'(rq1.pop_front());
        end
    end

    // Engine model: answers each command handshake after a scripted delay (-1 = never).
    initial begin : engine
        eng_t e;
        m_rsp_valid_i = 1'b0;
        m_rdata_i     = 8'h00;
        m_nack_i      = 1'b0;
        forever begin
            @(negedge clk_i);
            if (m_valid_o && m_ready_i && !rst_i) begin
                eng_busy = 1'b1;
                if (eng_q.size() > 0) e = eng_q.pop_front();
                else e = '{0, 8'h00, 1'b0};
                @(posedge clk_i);
                #1;
                if (e.delay >= 0) begin
                    repeat (e.delay) begin
                        @(posedge clk_i);
                        #1;
                    end
                    m_rsp_valid_i = 1'b1;
                    m_rdata_i     = e.rdata;
                    m_nack_i      = e.nack;
                    @(posedge clk_i);
                    #1;
                    m_rsp_valid_i = 1'b0;
                    m_rdata_i     = 8'h00;
                    m_nack_i      = 1'b0;
                end
                eng_busy = 1'b0;
            end
        end
    end

    // Monitor: command channel and response channel against the scoreboard queues.
    always @(negedge clk_i) begin
        if (m_valid_o) begin
            mv_cycles++;
            if (exp_cmd.size() == 0) begin
                chk("unexpected_cmd", 32'(m_valid_o), 32'h0);
            end else begin
                chk("cmd_fields", 32'({m_rnw_o, m_dev_o, m_reg_o, m_wdata_o}), 32'(exp_cmd[0].c));
                chk("cmd_grant", 32'(grant_o), 32'(1) << exp_cmd[0].k);
                chk("cmd_busy", 32'(busy_o), 32'h1);
                if (m_ready_i) begin
                    hs_count++;
                    hs_cyc = cyc;
                    void'(exp_cmd.pop_front());
                end
            end
        end
        if (rsp_valid_o != '0) begin
            rsp_cyc = cyc;
            if (exp_rsp.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid_o), 32'h0);
            end else begin
                chk("rsp_valid", 32'(rsp_valid_o), 32'(1) << exp_rsp[0].k);
                chk("rsp_rdata", 32'(rsp_rdata_o), 32'(exp_rsp[0].rdata));
                chk("rsp_err", 32'(rsp_err_o), 32'(exp_rsp[0].err));
                if (exp_rsp[0].lat >= 0)
                    chk("rsp_latency", 32'(cyc - acc_cyc[exp_rsp[0].k]), 32'(exp_rsp[0].lat));
                void'(exp_rsp.pop_front());
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk_i);
        while ((rq0.size() > 0 || rq1.size() > 0 || exp_cmd.size() > 0 || exp_rsp.size() > 0 ||
                busy_o || eng_busy) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk("idle_within_budget", 32'(n < budget), 32'h1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin : main
        int hs0;
        int mv0;
        int n;
        rst_i     = 1'b1;
        m_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("reset_busy", 32'(busy_o), 32'h0);
        chk("reset_grant", 32'(grant_o), 32'h0);
        chk("reset_m_valid", 32'(m_valid_o), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("reset_timeout", 32'(timeout_o), 32'h0);
        chk("reset_req_ready", 32'(req_ready_o), 32'h0);
        rst_i = 1'b0;

        // Single write from requester 0; engine answers on WAIT entry, data must read back 0.
        // accept..RESP spans 4 cycles inclusive, i.e. RESP 3 cycles after the accept cycle.
        exp_cmd.push_back('{0, '{1'b0, 7'h74, 8'h01, 8'h0B}});
        eng_q.push_back('{0, 8'h99, 1'b0});
        exp_rsp.push_back('{0, 8'h00, 1'b0, 3});
        rq0.push_back('{1'b0, 7'h74, 8'h01, 8'h0B});
        wait_idle(40);

        // Reset during WAIT (rr_ptr is 1 here): no response, engine's late reply ignored.
        exp_cmd.push_back('{1, '{1'b1, 7'h74, 8'h10, 8'h00}});
        eng_q.push_back('{6, 8'hAA, 1'b1});
        hs0 = hs_count;
        rq1.push_back('{1'b1, 7'h74, 8'h10, 8'h00});
        n = 0;
        while (hs_count == hs0 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("abort_handshake_seen", 32'(hs_count - hs0), 32'h1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("abort_busy", 32'(busy_o), 32'h0);
        chk("abort_grant", 32'(grant_o), 32'h0);
        chk("abort_m_valid", 32'(m_valid_o), 32'h0);
        rst_i = 1'b0;
        wait_idle(40);

        // Contention: both requesters keep requesting; rr_ptr back at 0 so order is 0,1,0,1.
        exp_cmd.push_back('{0, '{1'b1, 7'h74, 8'h20, 8'h00}});
        exp_cmd.push_back('{1, '{1'b0, 7'h75, 8'h21, 8'hA1}});
        exp_cmd.push_back('{0, '{1'b0, 7'h74, 8'h22, 8'hA2}});
        exp_cmd.push_back('{1, '{1'b1, 7'h75, 8'h23, 8'h00}});
        eng_q.push_back('{0, 8'h11, 1'b0});
        eng_q.push_back('{0, 8'h33, 1'b0});
        eng_q.push_back('{1, 8'h44, 1'b0});
        eng_q.push_back('{0, 8'h22, 1'b0});
        exp_rsp.push_back('{0, 8'h11, 1'b0, -1});
        exp_rsp.push_back('{1, 8'h00, 1'b0, -1});
        exp_rsp.push_back('{0, 8'h00, 1'b0, -1});
        exp_rsp.push_back('{1, 8'h22, 1'b0, -1});
        rq0.push_back('{1'b1, 7'h74, 8'h20, 8'h00});
        rq0.push_back('{1'b0, 7'h74, 8'h22, 8'hA2});
        rq1.push_back('{1'b0, 7'h75, 8'h21, 8'hA1});
        rq1.push_back('{1'b1, 7'h75, 8'h23, 8'h00});
        wait_idle(80);

        // Read with NACK from requester 1.
        exp_cmd.push_back('{1, '{1'b1, 7'h74, 8'hFE, 8'h00}});
        eng_q.push_back('{2, 8'h5A, 1'b1});
        exp_rsp.push_back('{1, 8'h5A, 1'b1, -1});
        rq1.push_back('{1'b1, 7'h74, 8'hFE, 8'h00});
        wait_idle(40);

        // Backpressure: engine not ready for 10 m_valid cycles.
        m_ready_i = 1'b0;
        mv0 = mv_cycles;
        hs0 = hs_count;
        exp_cmd.push_back('{0, '{1'b0, 7'h74, 8'h33, 8'h5C}});
        eng_q.push_back('{0, 8'hC3, 1'b0});
        exp_rsp.push_back('{0, 8'h00, 1'b0, -1});
        rq0.push_back('{1'b0, 7'h74, 8'h33, 8'h5C});
        n = 0;
        while (!m_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("bp_m_valid_seen", 32'(m_valid_o), 32'h1);
        repeat (9) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        m_ready_i = 1'b1;
        wait_idle(40);
        chk("bp_m_valid_cycles", 32'(mv_cycles - mv0), 32'd11);
        chk("bp_handshakes", 32'(hs_count - hs0), 32'd1);

`ifdef ARB_TIMEOUT_EN
        // Watchdog: engine never answers; RESP 16 cycles after WAIT entry.
        exp_cmd.push_back('{1, '{1'b1, 7'h74, 8'h05, 8'h00}});
        eng_q.push_back('{-1, 8'h00, 1'b0});
        exp_rsp.push_back('{1, 8'h00, 1'b1, -1});
        rq1.push_back('{1'b1, 7'h74, 8'h05, 8'h00});
        wait_idle(60);
        chk("to_resp_delay", 32'(rsp_cyc - (hs_cyc + 1)), 32'd16);
        chk("to_flag_set", 32'(timeout_o), 32'h1);
        repeat (3) @(negedge clk_i);
        chk("to_flag_sticky", 32'(timeout_o), 32'h1);
        do_reset();
        chk("to_flag_cleared", 32'(timeout_o), 32'h0);
`else
        chk("timeout_tied_low", 32'(timeout_o), 32'h0);
        do_reset();
        chk("post_reset_idle", 32'(busy_o), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : guard
        repeat (20000) @(posedge clk_i);
        miscompares++;
        $display("FAIL global_cycle_budget: got %0d cycles, expected completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "cycle budget exhausted");
    end

endmodule
